// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 key schedule.
// Holds the expander FSM state encoding and round-key sizing.
package aes128_pkg;

   localparam int RK_W           = 128;
   localparam int AES_NUM_ROUNDS = 10;

   typedef enum logic [1:0] {
      IDLE,
      EMIT,
      FETCH,
      CALC
   } ks_state_t;

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational (0 cycles, no flow control).
// Multiplicative inverse in GF(2^8) via x^254, then the FIPS-197 affine map.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = '0;
      aa = x;
      bb = y;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

   // Addition chain for x^254; zero maps to zero as the S-box requires.
   assign x2   = gmul(a, a);
   assign x3   = gmul(x2, a);
   assign x6   = gmul(x3, x3);
   assign x12  = gmul(x6, x6);
   assign x15  = gmul(x12, x3);
   assign x30  = gmul(x15, x15);
   assign x60  = gmul(x30, x30);
   assign x120 = gmul(x60, x60);
   assign x240 = gmul(x120, x120);
   assign x252 = gmul(x240, x12);
   assign inv  = gmul(x252, x2);

   assign s = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;

endmodule

// File: rtl/aes128_key_expand.sv
// AES-128 key expander: first round key 1 cycle after start, then one every 3 cycles.
// Each round key is held on rk_data/rk_index until rk_valid & rk_ready; a low rk_ready stalls indefinitely.
module aes128_key_expand
   import aes128_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
   parameter int RCON_AW    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [RK_W-1:0]     key_in,
   output logic                busy,
   output logic                done,
   output logic [RCON_AW-1:0]  rcon_address0,
   output logic                rcon_ce0,
   input  logic [7:0]          rcon_q0,
   output logic [RK_W-1:0]     rk_data,
   output logic [3:0]          rk_index,
   output logic                rk_valid,
   input  logic                rk_ready
);

   ks_state_t state;

   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot_w, sub_w, t_w;
   logic [31:0] n0, n1, n2, n3;

   // rk_data doubles as the working key register.
   assign {w0, w1, w2, w3} = rk_data;
   assign rot_w = {w3[23:0], w3[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sub
      aes_sbox u_sbox (
         .a (rot_w[8*i +: 8]),
         .s (sub_w[8*i +: 8])
      );
   end

   assign t_w = sub_w ^ {rcon_q0, 24'h0};
   assign n0  = w0 ^ t_w;
   assign n1  = w1 ^ n0;
   assign n2  = w2 ^ n1;
   assign n3  = w3 ^ n2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         rk_data       <= '0;
         rk_index      <= '0;
         rk_valid      <= 1'b0;
         done          <= 1'b0;
         busy          <= 1'b0;
         rcon_ce0      <= 1'b0;
         rcon_address0 <= '0;
      end else begin
         done     <= 1'b0;
         rcon_ce0 <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rk_data  <= key_in;
                  rk_index <= '0;
                  rk_valid <= 1'b1;
                  busy     <= 1'b1;
                  state    <= EMIT;
               end
            end
            EMIT: begin
               if (rk_ready) begin
                  rk_valid <= 1'b0;
                  if (rk_index == 4'(NUM_ROUNDS)) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     // Rcon entry rk_index serves round rk_index+1.
                     rcon_ce0      <= 1'b1;
                     rcon_address0 <= RCON_AW'(rk_index);
                     state         <= FETCH;
                  end
               end
            end
            FETCH: begin
               state <= CALC;
            end
            CALC: begin
               rk_data  <= {n0, n1, n2, n3};
               rk_index <= rk_index + 4'd1;
               rk_valid <= 1'b1;
               state    <= EMIT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/aes128_key_expand.md
AES128_KEY_EXPAND -- requirements
Module: aes128_key_expand

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, number of expanded round keys after the cipher key.
REQ-002 SHALL have parameter RCON_AW, default 4, Rcon ROM address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to expand key_in; sampled only in IDLE.
REQ-006 SHALL have port key_in  input  128  cipher key; word w0 = key_in[127:96].
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse after the last round key handshake.
REQ-009 SHALL have port rcon_address0  output  RCON_AW  Rcon ROM read address.
REQ-010 SHALL have port rcon_ce0  output  1  Rcon ROM read enable.
REQ-011 SHALL have port rcon_q0  input  8  Rcon ROM data, valid one cycle after the rcon_ce0 cycle.
REQ-012 SHALL have port rk_data  output  128  current round key.
REQ-013 SHALL have port rk_index  output  4  round number of rk_data, 0..NUM_ROUNDS.
REQ-014 SHALL have port rk_valid  output  1  rk_data/rk_index valid.
REQ-015 SHALL have port rk_ready  input  1  downstream accepts; transfer when rk_valid and rk_ready are both high.

Function
REQ-016 SHALL implement FSM states IDLE, EMIT, FETCH, CALC.
REQ-017 IDLE with start=1 SHALL load key_in into the key register, set rk_index=0, and enter EMIT next cycle.
REQ-018 EMIT SHALL drive rk_valid=1 and hold rk_data/rk_index stable until handshake; rk_ready low stalls indefinitely.
REQ-019 EMIT handshake with rk_index=NUM_ROUNDS SHALL enter IDLE and pulse done for exactly that next cycle; otherwise it SHALL enter FETCH.
REQ-020 FETCH SHALL assert rcon_ce0=1 for exactly one cycle with rcon_address0=rk_index (Rcon for round rk_index+1), then enter CALC.
REQ-021 CALC SHALL compute t = SubWord(RotWord(w3)) XOR {rcon_q0,24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'; register the result, increment rk_index, and enter EMIT.
REQ-022 rcon_ce0 SHALL be 0 outside FETCH; rcon_address0 SHALL hold its last value outside FETCH.
REQ-023 Latency: first rk_valid 1 cycle after start is accepted; each subsequent rk_valid exactly 3 cycles after the previous handshake (EMIT->FETCH->CALC->EMIT).
REQ-024 start while busy SHALL be ignored, with no effect on key, index or outputs.
REQ-025 rk_valid SHALL be 0 in IDLE, FETCH and CALC.
REQ-026 done and start in the same cycle SHALL accept the new start (IDLE behaviour).

Reset
REQ-027 reset SHALL asynchronously force state=IDLE, key register=0, rk_index=0, rk_valid=0, done=0, busy=0, rcon_ce0=0, rcon_address0=0.
REQ-028 reset asserted mid-expansion SHALL abandon the expansion; no done pulse SHALL follow release.
REQ-029 The first start after reset release SHALL behave identically to a start from power-up.

Structure
REQ-030 A shared package aes128_pkg SHALL hold the FSM state enum, the round-key width constant (128), and the NUM_ROUNDS default.
REQ-031 The S-box SHALL be one combinational sub-module aes_sbox (8-bit in, 8-bit out), instantiated four times for SubWord.
REQ-032 The Rcon ROM SHALL be external to this block and connected through the rcon_* ports.

Verification
REQ-033 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> idx0 = key, idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6, done pulse, 11 handshakes total.
REQ-034 All-zero key -> idx1 = 62636363626363636263636362636363; rcon_address0 sequence 0..9 observed, one rcon_ce0 pulse each.
REQ-035 rk_ready low for 5 cycles at idx3 -> rk_data/rk_index stable, no rcon_ce0 during the stall, correct idx4 afterwards.
REQ-036 start pulsed again at idx5 with a different key_in -> ignored; the full original-key sequence completes.
REQ-037 reset asserted in CALC of round 6 -> all outputs 0 immediately; a new start then reproduces the REQ-033 sequence from idx0.
